// File: rtl/l2_pkg.sv
// L2 responder shared definitions: geometry, line/address types, FSM states
// and address field helpers.
package l2_pkg;

    localparam int unsigned TNUM_2    = 18;
    localparam int unsigned INUM_2    = 26 - TNUM_2;
    localparam int unsigned L21BUS    = 512;
    localparam int unsigned L2_OFFSET = 6;
    localparam int unsigned L2_WAYS   = 2;
    localparam int unsigned L2_SETS   = 1 << INUM_2;

    typedef logic [L21BUS-1:0] l2_line_t;
    typedef logic [TNUM_2-1:0] l2_tag_t;
    typedef logic [INUM_2-1:0] l2_idx_t;

    typedef struct packed {
        l2_tag_t                tag;
        l2_idx_t                idx;
        logic [L2_OFFSET-1:0]   off;
    } l2_addr_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        WB     = 3'd2,
        FETCH  = 3'd3,
        RESP   = 3'd4
    } l2_state_t;

    // Split a byte address into tag / index / offset fields.
    function automatic l2_addr_t addr_split(input logic [31:0] a);
        return l2_addr_t'(a);
    endfunction

    // Rebuild a line-aligned address from tag and index.
    function automatic logic [31:0] line_addr(input l2_tag_t tag, input l2_idx_t idx);
        return {tag, idx, {L2_OFFSET{1'b0}}};
    endfunction

endpackage

// File: rtl/l2_tag_array.sv
// 2-way tag store: valid, dirty, tag and LRU per set with combinational compare.
// Ports:
//   clk, nrst        clock, async active-low reset (clears valid/dirty/LRU)
//   idx, tag         lookup set and tag
//   upd_*            write one way of set idx: tag, valid=1, dirty=upd_dirty
//   lru_en, lru_way  mark lru_way as most recently used in set idx
//   hit, hit_way     lookup result
//   victim_*         replacement choice and its dirty state / tag
module l2_tag_array
    import l2_pkg::*;
(
    input  logic    clk,
    input  logic    nrst,
    input  l2_idx_t idx,
    input  l2_tag_t tag,
    input  logic    upd_en,
    input  logic    upd_way,
    input  l2_tag_t upd_tag,
    input  logic    upd_dirty,
    input  logic    lru_en,
    input  logic    lru_way,
    output logic    hit,
    output logic    hit_way,
    output logic    victim_way,
    output logic    victim_dirty,
    output l2_tag_t victim_tag
);

    logic [L2_SETS-1:0] valid_q [L2_WAYS];
    logic [L2_SETS-1:0] dirty_q [L2_WAYS];
    logic [L2_SETS-1:0] lru_q;
    l2_tag_t            tag_q   [L2_WAYS][L2_SETS];

    logic hit0;
    logic hit1;

    // Status bits: cleared by reset; lru_q holds the way to evict next.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int w = 0; w < int'(L2_WAYS); w++) begin
                valid_q[w] <= '0;
                dirty_q[w] <= '0;
            end
            lru_q <= '0;
        end else begin
            if (upd_en) begin
                valid_q[upd_way][idx] <= 1'b1;
                dirty_q[upd_way][idx] <= upd_dirty;
            end
            if (lru_en) begin
                lru_q[idx] <= ~lru_way;
            end
        end
    end

    // Tags are qualified by valid, so they need no reset.
    always_ff @(posedge clk) begin
        if (upd_en) begin
            tag_q[upd_way][idx] <= upd_tag;
        end
    end

    assign hit0 = valid_q[0][idx] && (tag_q[0][idx] == tag);
    assign hit1 = valid_q[1][idx] && (tag_q[1][idx] == tag);
    assign hit     = hit0 | hit1;
    assign hit_way = hit1;

    // Invalid way first (way0 preferred), otherwise LRU.
    always_comb begin
        victim_way = lru_q[idx];
        if (!valid_q[0][idx]) begin
            victim_way = 1'b0;
        end else if (!valid_q[1][idx]) begin
            victim_way = 1'b1;
        end
    end

    assign victim_dirty = valid_q[victim_way][idx] & dirty_q[victim_way][idx];
    assign victim_tag   = tag_q[victim_way][idx];

endmodule

// File: rtl/l2_l1_responder.sv
// L2 responder: serves L1 line refills and accepts L1 dirty write-backs from a
// 2-way set-associative L2; misses evict a dirty victim then fetch from memory.
// Optional macro L2_PERF_CNT_EN adds saturating hit/miss/write-back counters.
// Ports:
//   clk, nrst                     clock, async active-low reset
//   *_L1_L2 / *_L2_L1             L1 request (held until ready) and response pulse
//   *_L2_M / *_M_L2               memory request (held until ready) and completion
//   hit_cnt, miss_cnt, wb_cnt     performance counters (L2_PERF_CNT_EN only)
module l2_l1_responder
    import l2_pkg::*;
(
    input  logic              clk,
    input  logic              nrst,
    input  logic              req_L1_L2,
    input  logic              write_L1_L2,
    input  logic [31:0]       address_L1_L2,
    input  logic [L21BUS-1:0] write_data_L1_L2,
    output logic [L21BUS-1:0] read_data_L2_L1,
    output logic              ready_L2_L1,
    output logic              req_L2_M,
    output logic              write_L2_M,
    output logic [31:0]       address_L2_M,
    output logic [L21BUS-1:0] write_data_L2_M,
    input  logic [L21BUS-1:0] read_data_M_L2,
    input  logic              ready_M_L2
`ifdef L2_PERF_CNT_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt,
    output logic [31:0]       wb_cnt
`endif
);

    l2_state_t state;
    logic      write_q;
    l2_tag_t   tag_q;
    l2_idx_t   idx_q;
    l2_line_t  wdata_q;
    logic      way_q;
    l2_tag_t   vtag_q;

    l2_addr_t  req_addr;
    logic      unused_offset;

    logic      hit, hit_way, victim_way, victim_dirty;
    l2_tag_t   victim_tag;

    logic      upd_en, upd_way, upd_dirty, lru_en;
    l2_tag_t   upd_tag;
    logic      data_we, data_way;
    l2_line_t  data_wdata;

    l2_line_t  data_mem [L2_WAYS][L2_SETS];

    assign req_addr      = addr_split(address_L1_L2);
    assign unused_offset = ^req_addr.off;

    l2_tag_array u_tags (
        .clk          (clk),
        .nrst         (nrst),
        .idx          (idx_q),
        .tag          (tag_q),
        .upd_en       (upd_en),
        .upd_way      (upd_way),
        .upd_tag      (upd_tag),
        .upd_dirty    (upd_dirty),
        .lru_en       (lru_en),
        .lru_way      (way_q),
        .hit          (hit),
        .hit_way      (hit_way),
        .victim_way   (victim_way),
        .victim_dirty (victim_dirty),
        .victim_tag   (victim_tag)
    );

    // Tag/data array write strobes for the current state.
    always_comb begin
        upd_en     = 1'b0;
        upd_way    = way_q;
        upd_tag    = tag_q;
        upd_dirty  = 1'b0;
        lru_en     = 1'b0;
        data_we    = 1'b0;
        data_way   = way_q;
        data_wdata = wdata_q;
        case (state)
            LOOKUP: begin
                if (write_q && (hit || !victim_dirty)) begin
                    // write hit, or write-allocate into a clean/empty victim
                    data_we   = 1'b1;
                    data_way  = hit ? hit_way : victim_way;
                    upd_en    = 1'b1;
                    upd_way   = data_way;
                    upd_dirty = 1'b1;
                end
            end
            WB: begin
                if (ready_M_L2) begin
                    upd_en = 1'b1;
                    if (write_q) begin
                        data_we   = 1'b1;
                        upd_dirty = 1'b1;
                    end else begin
                        upd_tag = vtag_q;
                    end
                end
            end
            FETCH: begin
                if (req_L2_M && ready_M_L2) begin
                    data_we    = 1'b1;
                    data_wdata = read_data_M_L2;
                    upd_en     = 1'b1;
                end
            end
            RESP:    lru_en = 1'b1;
            default: ;
        endcase
    end

    // Line storage has no reset.
    always_ff @(posedge clk) begin
        if (data_we) begin
            data_mem[data_way][idx_q] <= data_wdata;
        end
    end

    // Control FSM with registered L1 and memory outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state           <= IDLE;
            write_q         <= 1'b0;
            tag_q           <= '0;
            idx_q           <= '0;
            wdata_q         <= '0;
            way_q           <= 1'b0;
            vtag_q          <= '0;
            read_data_L2_L1 <= '0;
            ready_L2_L1     <= 1'b0;
            req_L2_M        <= 1'b0;
            write_L2_M      <= 1'b0;
            address_L2_M    <= '0;
            write_data_L2_M <= '0;
        end else begin
            ready_L2_L1     <= 1'b0;
            read_data_L2_L1 <= '0;
            case (state)
                IDLE: begin
                    if (req_L1_L2) begin
                        write_q <= write_L1_L2;
                        tag_q   <= req_addr.tag;
                        idx_q   <= req_addr.idx;
                        wdata_q <= write_data_L1_L2;
                        state   <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    way_q  <= hit ? hit_way : victim_way;
                    vtag_q <= victim_tag;
                    if (hit) begin
                        if (!write_q) begin
                            read_data_L2_L1 <= data_mem[hit_way][idx_q];
                        end
                        ready_L2_L1 <= 1'b1;
                        state       <= RESP;
                    end else if (victim_dirty) begin
                        req_L2_M        <= 1'b1;
                        write_L2_M      <= 1'b1;
                        address_L2_M    <= line_addr(victim_tag, idx_q);
                        write_data_L2_M <= data_mem[victim_way][idx_q];
                        state           <= WB;
                    end else if (!write_q) begin
                        req_L2_M     <= 1'b1;
                        write_L2_M   <= 1'b0;
                        address_L2_M <= line_addr(tag_q, idx_q);
                        state        <= FETCH;
                    end else begin
                        ready_L2_L1 <= 1'b1;
                        state       <= RESP;
                    end
                end
                WB: begin
                    if (ready_M_L2) begin
                        req_L2_M        <= 1'b0;
                        write_L2_M      <= 1'b0;
                        address_L2_M    <= '0;
                        write_data_L2_M <= '0;
                        if (write_q) begin
                            ready_L2_L1 <= 1'b1;
                            state       <= RESP;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (!req_L2_M) begin
                        // re-raise after the write-back so the request drops for a cycle
                        req_L2_M     <= 1'b1;
                        address_L2_M <= line_addr(tag_q, idx_q);
                    end else if (ready_M_L2) begin
                        req_L2_M        <= 1'b0;
                        address_L2_M    <= '0;
                        read_data_L2_L1 <= read_data_M_L2;
                        ready_L2_L1     <= 1'b1;
                        state           <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef L2_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Saturating event counters.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            wb_cnt   <= '0;
        end else begin
            if (state == LOOKUP) begin
                if (hit) begin
                    hit_cnt <= sat_inc(hit_cnt);
                end else begin
                    miss_cnt <= sat_inc(miss_cnt);
                end
            end
            if ((state == WB) && ready_M_L2) begin
                wb_cnt <= sat_inc(wb_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_l2_l1_responder.sv
// Self-checking bench for l2_l1_responder: randomized L1 traffic against a
// coherent-memory reference view plus a 2-way replacement model; a memory
// responder and an L1 monitor check traffic independently of the stimulus.
module tb_l2_l1_responder;
    import l2_pkg::*;

    logic              clk = 1'b0;
    logic              nrst = 1'b0;
    logic              req_L1_L2 = 1'b0;
    logic              write_L1_L2 = 1'b0;
    logic [31:0]       address_L1_L2 = '0;
    logic [L21BUS-1:0] write_data_L1_L2 = '0;
    logic [L21BUS-1:0] read_data_L2_L1;
    logic              ready_L2_L1;
    logic              req_L2_M;
    logic              write_L2_M;
    logic [31:0]       address_L2_M;
    logic [L21BUS-1:0] write_data_L2_M;
    logic [L21BUS-1:0] read_data_M_L2 = '0;
    logic              ready_M_L2 = 1'b0;

    l2_l1_responder dut (
        .clk              (clk),
        .nrst             (nrst),
        .req_L1_L2        (req_L1_L2),
        .write_L1_L2      (write_L1_L2),
        .address_L1_L2    (address_L1_L2),
        .write_data_L1_L2 (write_data_L1_L2),
        .read_data_L2_L1  (read_data_L2_L1),
        .ready_L2_L1      (ready_L2_L1),
        .req_L2_M         (req_L2_M),
        .write_L2_M       (write_L2_M),
        .address_L2_M     (address_L2_M),
        .write_data_L2_M  (write_data_L2_M),
        .read_data_M_L2   (read_data_M_L2),
        .ready_M_L2       (ready_M_L2)
    );

    initial forever #5 clk = ~clk;

    typedef struct { l2_line_t rdata; bit fast; int unsigned cyc; } l1_exp_t;
    typedef struct { bit wr; logic [31:0] addr; l2_line_t data; } mem_exp_t;

    l1_exp_t     l1_q[$];
    mem_exp_t    mem_q[$];
    l2_line_t    view      [logic [31:0]];
    l2_line_t    mem_store [logic [31:0]];
    bit          m_valid [2][256];
    bit          m_dirty [2][256];
    bit          m_lru   [256];
    logic [17:0] m_tag   [2][256];

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned cyc = 0;
    bit          abort = 0;
    int          force_lat = -1;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
        $fatal(1);
    end

    function automatic l2_line_t init_line(input logic [31:0] a);
        if (a == 32'h0000_0040) return {64{8'hA5}};
        return {16{a ^ 32'h5A5A_0F0F}};
    endfunction

    function automatic l2_line_t view_rd(input logic [31:0] a);
        if (view.exists(a)) return view[a];
        return init_line(a);
    endfunction

    function automatic l2_line_t mem_rd(input logic [31:0] a);
        if (mem_store.exists(a)) return mem_store[a];
        return init_line(a);
    endfunction

    function automatic l2_line_t rand_line();
        l2_line_t l;
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic check(input string name, input l2_line_t act, input l2_line_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Predict the outcome of one L1 access: expected memory traffic and response.
    function automatic void model_access(input bit w, input logic [31:0] a, input l2_line_t d);
        logic [31:0] al;
        logic [7:0]  idx;
        logic [17:0] tag;
        int          way;
        bit          fast;
        mem_exp_t    me;
        l1_exp_t     le;
        al   = {a[31:6], 6'd0};
        idx  = a[13:6];
        tag  = a[31:14];
        way  = -1;
        fast = 1;
        for (int i = 0; i < 2; i++)
            if (m_valid[i][idx] && m_tag[i][idx] == tag) way = i;
        if (way < 0) begin
            way = !m_valid[0][idx] ? 0 : (!m_valid[1][idx] ? 1 : int'(m_lru[idx]));
            if (m_valid[way][idx] && m_dirty[way][idx]) begin
                me.wr   = 1;
                me.addr = {m_tag[way][idx], idx, 6'd0};
                me.data = view_rd(me.addr);
                mem_q.push_back(me);
                fast = 0;
            end
            if (!w) begin
                me.wr   = 0;
                me.addr = al;
                me.data = '0;
                mem_q.push_back(me);
                fast = 0;
            end
            m_valid[way][idx] = 1;
            m_tag[way][idx]   = tag;
            m_dirty[way][idx] = w;
        end else if (w) begin
            m_dirty[way][idx] = 1;
        end
        m_lru[idx] = (way == 0);
        if (w) view[al] = d;
        le.rdata = w ? '0 : view_rd(al);
        le.fast  = fast;
        le.cyc   = cyc;
        l1_q.push_back(le);
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < 256; s++) begin
            m_lru[s] = 0;
            for (int w = 0; w < 2; w++) begin
                m_valid[w][s] = 0;
                m_dirty[w][s] = 0;
            end
        end
        // dirty lines are lost; L1 now sees whatever memory holds
        view = mem_store;
    endfunction

    // Memory responder: checks each new request and answers after a random delay.
    initial begin
        bit          busy = 0;
        bit          cur_wr = 0;
        logic [31:0] cur_addr = '0;
        int          wait_cnt = 0;
        mem_exp_t    e;
        forever begin
            @(negedge clk);
            ready_M_L2     = 1'b0;
            read_data_M_L2 = '0;
            if (!nrst) begin
                busy = 0;
            end else if (req_L2_M) begin
                if (!busy) begin
                    busy     = 1;
                    cur_wr   = write_L2_M;
                    cur_addr = address_L2_M;
                    wait_cnt = (force_lat >= 0 && !write_L2_M) ? force_lat : int'($urandom_range(0, 3));
                    if (mem_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL mem_req_unexpected: got request addr %h write %0d, required none",
                                 address_L2_M, write_L2_M);
                    end else begin
                        e = mem_q.pop_front();
                        check("mem_write_flag", L21BUS'(write_L2_M), L21BUS'(e.wr));
                        check("mem_addr", L21BUS'(address_L2_M), L21BUS'(e.addr));
                        if (e.wr) check("mem_wb_data", write_data_L2_M, e.data);
                    end
                    if (write_L2_M) mem_store[address_L2_M] = write_data_L2_M;
                end
                if (wait_cnt == 0) begin
                    ready_M_L2 = 1'b1;
                    if (!cur_wr) read_data_M_L2 = mem_rd(cur_addr);
                    busy = 0;
                end else begin
                    wait_cnt--;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                // stray completion while idle must be ignored
                ready_M_L2     = 1'b1;
                read_data_M_L2 = rand_line();
            end
        end
    end

    // L1 monitor: pops the expected response whenever ready_L2_L1 is seen.
    initial begin
        l1_exp_t e;
        forever begin
            @(negedge clk);
            if (nrst && ready_L2_L1) begin
                if (l1_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL l1_resp_unexpected: got ready_L2_L1 data %h, required none", read_data_L2_L1);
                end else begin
                    e = l1_q.pop_front();
                    check("l1_rdata", read_data_L2_L1, e.rdata);
                    if (e.fast) check("l1_fast_latency", L21BUS'(cyc - e.cyc), L21BUS'(2));
                end
            end
        end
    end

    task automatic do_req(input bit w, input logic [31:0] a, input l2_line_t d);
        bit got;
        if (abort) return;
        @(negedge clk);
        model_access(w, a, d);
        req_L1_L2        = 1'b1;
        write_L1_L2      = w;
        address_L1_L2    = a;
        write_data_L1_L2 = d;
        got = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ready_L2_L1) begin
                got = 1;
                break;
            end
            // already sampled: later changes must have no effect
            write_L1_L2      = 1'($urandom_range(0, 1));
            address_L1_L2    = $urandom;
            write_data_L1_L2 = rand_line();
        end
        req_L1_L2 = 1'b0;
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL l1_timeout: got no ready_L2_L1 for addr %h, required one within 100 cycles", a);
            abort = 1;
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic rand_req();
        logic [31:0] a;
        a = (32'($urandom_range(0, 3)) << 14) | (32'($urandom_range(1, 3)) << 6) | 32'($urandom_range(0, 63));
        do_req($urandom_range(0, 2) == 0, a, rand_line());
    endtask

    initial begin
        bit got;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_ready", L21BUS'(ready_L2_L1), '0);
        check("rst_rdata", read_data_L2_L1, '0);
        check("rst_req_m", L21BUS'(req_L2_M), '0);
        check("rst_write_m", L21BUS'(write_L2_M), '0);
        check("rst_addr_m", L21BUS'(address_L2_M), '0);
        check("rst_wdata_m", write_data_L2_M, '0);
        nrst = 1'b1;

        do_req(0, 32'h0000_0040, '0);
        do_req(0, 32'h0000_0040, '0);
        do_req(1, 32'h0004_0040, {32{16'h1234}});
        do_req(0, 32'h0004_0040, '0);
        do_req(0, 32'h0008_0040, '0);
        do_req(0, 32'h000C_0040, '0);

        for (int i = 0; i < 250; i++) rand_req();

        // reset while a fetch is outstanding
        if (!abort) begin
            @(negedge clk);
            model_access(0, 32'h0010_0040, '0);
            force_lat        = 1000;
            req_L1_L2        = 1'b1;
            write_L1_L2      = 1'b0;
            address_L1_L2    = 32'h0010_0040;
            got = 0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (req_L2_M && !write_L2_M) begin
                    got = 1;
                    break;
                end
            end
            check("fetch_seen_before_reset", L21BUS'(got), L21BUS'(1));
            nrst = 1'b0;
            #1;
            check("mid_rst_req_m", L21BUS'(req_L2_M), '0);
            check("mid_rst_ready", L21BUS'(ready_L2_L1), '0);
            check("mid_rst_addr_m", L21BUS'(address_L2_M), '0);
            req_L1_L2 = 1'b0;
            l1_q.delete();
            mem_q.delete();
            model_reset();
            force_lat = -1;
            repeat (2) @(negedge clk);
            nrst = 1'b1;
            do_req(0, 32'h0000_0040, '0);
        end

        for (int i = 0; i < 40; i++) rand_req();

        repeat (5) @(negedge clk);
        check("l1_queue_drained", L21BUS'(l1_q.size()), '0);
        check("mem_queue_drained", L21BUS'(mem_q.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
